// File: rtl/mem_subsystem_sa_pkg.sv
// ---------------------------------------------------------------------------
// mem_subsystem_sa_pkg
// Shared types for the set-associative write-back cache controller:
//   state_t    - controller FSM state encoding
//   req_kind_t - kind of request latched in IDLE
//   field_w()  - clog2 that never returns 0, so one-entry fields stay 1 bit
// ---------------------------------------------------------------------------
package mem_subsystem_sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOOKUP     = 3'd1,
        ST_WRITEBACK  = 3'd2,
        ST_REFILL     = 3'd3,
        ST_RESPOND    = 3'd4,
        ST_FLUSH_SCAN = 3'd5,
        ST_FLUSH_WB   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_FLUSH = 2'd2
    } req_kind_t;

    localparam int WORD_W = 32;

    // Width of a field able to index n entries; at least 1 bit.
    function automatic int field_w(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/mem_subsystem_sa_tag_array.sv
// ---------------------------------------------------------------------------
// cache_tag_array
// Per-way tag / valid / dirty / LRU-age storage for every set, with a
// combinational lookup of the addressed set.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   idx_i, tag_i       set index and tag used by compare and by all updates
//   way_i              way used by the read port and by all updates
//   hit_o, hit_way_o   tag match in the set and the matching way
//   victim_way_o       lowest invalid way, else the oldest (LRU) way
//   rd_valid_o/rd_dirty_o/rd_tag_o  state of entry (idx_i, way_i)
//   fill_i             install tag_i, valid=1, dirty=0
//   set_dirty_i        mark entry dirty
//   clr_dirty_i        mark entry clean (valid untouched)
//   touch_i            make way_i MRU; younger ways age by one
// ---------------------------------------------------------------------------
module cache_tag_array
    import mem_subsystem_sa_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 4,
    parameter int TAG_W = 28,
    parameter int IDX_W = 2,
    parameter int WAY_W = 1,
    parameter int AGE_W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [WAY_W-1:0] way_i,
    output logic             hit_o,
    output logic [WAY_W-1:0] hit_way_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             rd_valid_o,
    output logic             rd_dirty_o,
    output logic [TAG_W-1:0] rd_tag_o,
    input  logic             fill_i,
    input  logic             set_dirty_i,
    input  logic             clr_dirty_i,
    input  logic             touch_i
);

    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] dirty_q;
    logic [TAG_W-1:0]          tag_q [SETS][WAYS];
    logic [AGE_W-1:0]          age_q [SETS][WAYS];

    logic [WAY_W-1:0] inv_way_s;
    logic             inv_found_s;
    logic [WAY_W-1:0] lru_way_s;

    // Tag compare and victim selection for the addressed set.
    always_comb begin
        hit_o       = 1'b0;
        hit_way_o   = '0;
        inv_way_s   = '0;
        inv_found_s = 1'b0;
        lru_way_s   = '0;
        // Descending scan so the lowest-numbered qualifying way wins.
        for (int j = WAYS - 1; j >= 0; j--) begin
            if (valid_q[idx_i][j] && (tag_q[idx_i][j] == tag_i)) begin
                hit_o     = 1'b1;
                hit_way_o = WAY_W'(j);
            end else begin
                hit_o     = hit_o;
            end
            if (!valid_q[idx_i][j]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WAY_W'(j);
            end else begin
                inv_found_s = inv_found_s;
            end
            // Ages form a permutation of 0..WAYS-1, so exactly one way is oldest.
            if (age_q[idx_i][j] == AGE_W'(WAYS - 1)) begin
                lru_way_s = WAY_W'(j);
            end else begin
                lru_way_s = lru_way_s;
            end
        end
        victim_way_o = inv_found_s ? inv_way_s : lru_way_s;
        rd_valid_o   = valid_q[idx_i][way_i];
        rd_dirty_o   = dirty_q[idx_i][way_i];
        rd_tag_o     = tag_q[idx_i][way_i];
    end

    // Entry state and LRU ages; ages restart as the permutation way j = age j.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int j = 0; j < WAYS; j++) begin
                    tag_q[s][j] <= '0;
                    age_q[s][j] <= AGE_W'(j);
                end
            end
        end else begin
            if (fill_i) begin
                tag_q[idx_i][way_i]   <= tag_i;
                valid_q[idx_i][way_i] <= 1'b1;
                dirty_q[idx_i][way_i] <= 1'b0;
            end
            if (set_dirty_i) begin
                dirty_q[idx_i][way_i] <= 1'b1;
            end
            if (clr_dirty_i) begin
                dirty_q[idx_i][way_i] <= 1'b0;
            end
            if (touch_i) begin
                for (int j = 0; j < WAYS; j++) begin
                    if (WAY_W'(j) == way_i) begin
                        age_q[idx_i][j] <= '0;
                    end else if (age_q[idx_i][j] < age_q[idx_i][way_i]) begin
                        age_q[idx_i][j] <= age_q[idx_i][j] + AGE_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_subsystem_sa.sv
// ---------------------------------------------------------------------------
// mem_subsystem_sa
// N-way set-associative, write-back, write-allocate cache controller with a
// line-wide backing-memory port, true LRU per set and a flush of dirty lines.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   LOAD/STORE/FLUSH            level requests, held until their completion
//   input_address, input_data   word address {tag,index,offset}, store data
//   data                        last loaded word
//   load/store/flush_completed  one-cycle completion pulses
//   busy                        controller not in IDLE
//   mem_req/mem_we/mem_addr/mem_wdata  line request to backing memory
//   mem_rdata, mem_ack          refill line and one-cycle completion
// ---------------------------------------------------------------------------
module mem_subsystem_sa
    import mem_subsystem_sa_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WAYS           = 2,
    parameter int SETS           = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             LOAD,
    input  logic                             STORE,
    input  logic                             FLUSH,
    input  logic [ADDR_W-1:0]                input_address,
    input  logic [31:0]                      input_data,
    output logic [31:0]                      data,
    output logic                             load_completed,
    output logic                             store_completed,
    output logic                             flush_completed,
    output logic                             busy,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [32*WORDS_PER_LINE-1:0]     mem_wdata,
    input  logic [32*WORDS_PER_LINE-1:0]     mem_rdata,
    input  logic                             mem_ack
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W   = field_w(WAYS);
    localparam int AGE_W   = field_w(WAYS);
    localparam int N_LINES = SETS * WAYS;
    localparam int SEL_W   = $clog2(N_LINES);
    localparam int WAY_SH  = $clog2(WAYS);

    typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

    state_t            state_q, state_d;
    req_kind_t         kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [SEL_W-1:0]  scan_q, scan_d;
    logic [31:0]       data_q, data_d;
    logic              load_cpl_q, load_cpl_d;
    logic              store_cpl_q, store_cpl_d;
    logic              flush_cpl_q, flush_cpl_d;
    logic              busy_q;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    line_t             mem_wdata_q, mem_wdata_d;

    line_t             line_q [N_LINES];
    logic              line_we_s;
    line_t             line_wdata_s;
    logic [SEL_W-1:0]  line_sel_s;

    logic [TAG_W-1:0]  req_tag_s;
    logic [IDX_W-1:0]  req_idx_s;
    logic [OFF_W-1:0]  req_off_s;
    logic [IDX_W-1:0]  scan_set_s;
    logic [WAY_W-1:0]  scan_way_s;
    logic              flushing_s;
    logic              pulse_s;
    logic              ack_s;

    logic [IDX_W-1:0]  ta_idx_s;
    logic [WAY_W-1:0]  ta_way_s;
    logic              hit_s;
    logic [WAY_W-1:0]  hit_way_s;
    logic [WAY_W-1:0]  victim_way_s;
    logic              rd_valid_s;
    logic              rd_dirty_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic              fill_s, set_dirty_s, clr_dirty_s, touch_s;

    assign req_tag_s  = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx_s  = addr_q[OFF_W +: IDX_W];
    assign req_off_s  = addr_q[OFF_W-1:0];
    // Flush walks entries set-major: scan = set * WAYS + way.
    assign scan_set_s = IDX_W'(scan_q >> WAY_SH);
    assign scan_way_s = WAY_W'(scan_q & SEL_W'(WAYS - 1));
    assign flushing_s = (state_q == ST_FLUSH_SCAN) || (state_q == ST_FLUSH_WB);
    // The cycle a completion pulse is out, the requester may still hold its
    // request; holding off acceptance for that cycle avoids a duplicate.
    assign pulse_s    = load_cpl_q | store_cpl_q | flush_cpl_q;
    assign ack_s      = mem_req_q & mem_ack;

    // In LOOKUP the read port looks at the candidate victim so its dirty
    // state is available for the writeback decision in the same cycle.
    assign ta_idx_s   = flushing_s ? scan_set_s : req_idx_s;
    assign ta_way_s   = (state_q == ST_LOOKUP) ? victim_way_s :
                        (flushing_s ? scan_way_s : way_q);
    assign line_sel_s = flushing_s ? scan_q :
                        SEL_W'(SEL_W'(req_idx_s) * SEL_W'(WAYS) + SEL_W'(way_q));

    cache_tag_array #(
        .WAYS  (WAYS),
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W),
        .WAY_W (WAY_W),
        .AGE_W (AGE_W)
    ) u_tags (
        .clk_i        (CLK),
        .rst_i        (RST),
        .idx_i        (ta_idx_s),
        .tag_i        (req_tag_s),
        .way_i        (ta_way_s),
        .hit_o        (hit_s),
        .hit_way_o    (hit_way_s),
        .victim_way_o (victim_way_s),
        .rd_valid_o   (rd_valid_s),
        .rd_dirty_o   (rd_dirty_s),
        .rd_tag_o     (rd_tag_s),
        .fill_i       (fill_s),
        .set_dirty_i  (set_dirty_s),
        .clr_dirty_i  (clr_dirty_s),
        .touch_i      (touch_s)
    );

    // Next-state and datapath control for the controller FSM.
    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        way_d        = way_q;
        scan_d       = scan_q;
        data_d       = data_q;
        load_cpl_d   = 1'b0;
        store_cpl_d  = 1'b0;
        flush_cpl_d  = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        fill_s       = 1'b0;
        set_dirty_s  = 1'b0;
        clr_dirty_s  = 1'b0;
        touch_s      = 1'b0;
        line_we_s    = 1'b0;
        line_wdata_s = line_q[line_sel_s];

        case (state_q)
            ST_IDLE: begin
                if (pulse_s) begin
                    state_d = ST_IDLE;
                end else if (LOAD) begin
                    kind_d  = REQ_LOAD;
                    addr_d  = input_address;
                    wdata_d = input_data;
                    state_d = ST_LOOKUP;
                end else if (STORE) begin
                    kind_d  = REQ_STORE;
                    addr_d  = input_address;
                    wdata_d = input_data;
                    state_d = ST_LOOKUP;
                end else if (FLUSH) begin
                    kind_d  = REQ_FLUSH;
                    scan_d  = '0;
                    state_d = ST_FLUSH_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_LOOKUP: begin
                if (hit_s) begin
                    way_d   = hit_way_s;
                    state_d = ST_RESPOND;
                end else begin
                    way_d   = victim_way_s;
                    state_d = (rd_valid_s && rd_dirty_s) ? ST_WRITEBACK : ST_REFILL;
                end
            end

            // Each memory state issues in its first cycle (mem_req low on
            // entry), so mem_req always drops for a cycle after an ack.
            ST_WRITEBACK: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {rd_tag_s, req_idx_s, OFF_W'(0)};
                    mem_wdata_d = line_q[line_sel_s];
                end else if (ack_s) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    clr_dirty_s = 1'b1;
                    state_d     = ST_REFILL;
                end else begin
                    state_d     = ST_WRITEBACK;
                end
            end

            ST_REFILL: begin
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_tag_s, req_idx_s, OFF_W'(0)};
                end else if (ack_s) begin
                    mem_req_d    = 1'b0;
                    fill_s       = 1'b1;
                    line_we_s    = 1'b1;
                    line_wdata_s = mem_rdata;
                    state_d      = ST_RESPOND;
                end else begin
                    state_d      = ST_REFILL;
                end
            end

            ST_RESPOND: begin
                touch_s = 1'b1;
                if (kind_q == REQ_LOAD) begin
                    data_d     = line_q[line_sel_s][req_off_s];
                    load_cpl_d = 1'b1;
                end else begin
                    line_we_s               = 1'b1;
                    line_wdata_s[req_off_s] = wdata_q;
                    set_dirty_s             = 1'b1;
                    store_cpl_d             = 1'b1;
                end
                state_d = ST_IDLE;
            end

            ST_FLUSH_SCAN: begin
                if (rd_valid_s && rd_dirty_s) begin
                    state_d = ST_FLUSH_WB;
                end else if (scan_q == SEL_W'(N_LINES - 1)) begin
                    flush_cpl_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    scan_d      = scan_q + SEL_W'(1);
                end
            end

            // After the ack the same entry is rescanned; it is clean now, so
            // the scan simply advances past it.
            ST_FLUSH_WB: begin
                if (!mem_req_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {rd_tag_s, scan_set_s, OFF_W'(0)};
                    mem_wdata_d = line_q[line_sel_s];
                end else if (ack_s) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    clr_dirty_s = 1'b1;
                    state_d     = ST_FLUSH_SCAN;
                end else begin
                    state_d     = ST_FLUSH_WB;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers and all registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            kind_q      <= REQ_LOAD;
            addr_q      <= '0;
            wdata_q     <= '0;
            way_q       <= '0;
            scan_q      <= '0;
            data_q      <= '0;
            load_cpl_q  <= 1'b0;
            store_cpl_q <= 1'b0;
            flush_cpl_q <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            way_q       <= way_d;
            scan_q      <= scan_d;
            data_q      <= data_d;
            load_cpl_q  <= load_cpl_d;
            store_cpl_q <= store_cpl_d;
            flush_cpl_q <= flush_cpl_d;
            busy_q      <= (state_d != ST_IDLE);
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Line data storage with a single write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N_LINES; i++) begin
                line_q[i] <= '0;
            end
        end else if (line_we_s) begin
            line_q[line_sel_s] <= line_wdata_s;
        end
    end

    assign data            = data_q;
    assign load_completed  = load_cpl_q;
    assign store_completed = store_cpl_q;
    assign flush_completed = flush_cpl_q;
    assign busy            = busy_q;
    assign mem_req         = mem_req_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_mem_subsystem_sa.sv
module tb_mem_subsystem_sa;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_FLUSH = 2;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         LOAD = 1'b0, STORE = 1'b0, FLUSH = 1'b0;
    logic [31:0]  input_address = 32'h0;
    logic [31:0]  input_data = 32'h0;
    logic [31:0]  data;
    logic         load_completed, store_completed, flush_completed, busy;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = 128'h0;
    logic         mem_ack = 1'b0;

    int tests = 0;
    int fails = 0;

    mem_subsystem_sa #(.ADDR_W(32), .WAYS(2), .SETS(4), .WORDS_PER_LINE(4)) dut (
        .CLK(CLK), .RST(RST), .LOAD(LOAD), .STORE(STORE), .FLUSH(FLUSH),
        .input_address(input_address), .input_data(input_data), .data(data),
        .load_completed(load_completed), .store_completed(store_completed),
        .flush_completed(flush_completed), .busy(busy), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- backing memory model: ack 3 cycles after req ----------
    logic [31:0] mem_word [logic [31:0]];
    logic        log_we   [64];
    logic [31:0] log_addr [64];
    logic [31:0] log_w1   [64];
    int          log_n = 0;
    int          cnt = 0;
    logic [31:0] held_addr;
    logic        held_we;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_word.exists(a)) return mem_word[a];
        return 32'hA5A50000 | a;
    endfunction

    always @(negedge CLK) begin
        if (RST) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (cnt == 0) begin
                held_addr = mem_addr;
                held_we   = mem_we;
            end else begin
                chk("mem_hold_addr", mem_addr, held_addr);
                chk("mem_hold_we", {31'h0, mem_we}, {31'h0, held_we});
            end
            cnt++;
            if (cnt == 3) begin
                cnt = 0;
                mem_ack = 1'b1;
                if (log_n < 64) begin
                    log_we[log_n]   = mem_we;
                    log_addr[log_n] = mem_addr;
                    log_w1[log_n]   = mem_wdata[63:32];
                    log_n++;
                end
                for (int w = 0; w < 4; w++) begin
                    if (mem_we) mem_word[mem_addr + w] = mem_wdata[32*w +: 32];
                    else        mem_rdata[32*w +: 32] = rd_word(mem_addr + w);
                end
            end
        end
    end

    // ---------------- vector table ------------------------------------------
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_data;
        logic [31:0] exp_data;
        int          n_tx;
        logic        tx0_we;
        logic [31:0] tx0_addr;
        logic        tx1_we;
        logic [31:0] tx1_addr;
        logic [31:0] exp_w1;
        int          lat_lo;
        int          lat_hi;
    } vec_t;

    function automatic vec_t mk(int k, logic [31:0] a, logic [31:0] wd, bit cd,
                                logic [31:0] ed, int n, logic w0, logic [31:0] a0,
                                logic w1, logic [31:0] a1, logic [31:0] ew1,
                                int lo, int hi);
        vec_t v;
        v.kind = k; v.addr = a; v.wdata = wd; v.chk_data = cd; v.exp_data = ed;
        v.n_tx = n; v.tx0_we = w0; v.tx0_addr = a0; v.tx1_we = w1; v.tx1_addr = a1;
        v.exp_w1 = ew1; v.lat_lo = lo; v.lat_hi = hi;
        return v;
    endfunction

    task automatic wait_pulse(input int k, output int cyc, output bit ok, output int req_hi);
        ok = 1'b0; cyc = 0; req_hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            cyc++;
            if (mem_req) req_hi++;
            if ((k == K_LOAD && load_completed) || (k == K_STORE && store_completed) ||
                (k == K_FLUSH && flush_completed)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int  base;
        int  cyc;
        int  req_hi;
        bit  ok;
        base          = log_n;
        input_address = v.addr;
        input_data    = v.wdata;
        LOAD  = (v.kind == K_LOAD);
        STORE = (v.kind == K_STORE);
        FLUSH = (v.kind == K_FLUSH);
        wait_pulse(v.kind, cyc, ok, req_hi);
        LOAD = 1'b0; STORE = 1'b0; FLUSH = 1'b0;
        chk({nm, "_pulse"}, {31'h0, ok}, 32'h1);
        if (v.chk_data) chk({nm, "_data"}, data, v.exp_data);
        chk({nm, "_ntx"}, log_n - base, v.n_tx);
        for (int k = 0; k < v.n_tx && k < 2 && base + k < log_n; k++) begin
            chk($sformatf("%s_tx%0d_we", nm, k), {31'h0, log_we[base+k]},
                {31'h0, (k == 0) ? v.tx0_we : v.tx1_we});
            chk($sformatf("%s_tx%0d_addr", nm, k), log_addr[base+k],
                (k == 0) ? v.tx0_addr : v.tx1_addr);
            if (log_we[base+k]) chk($sformatf("%s_tx%0d_w1", nm, k), log_w1[base+k], v.exp_w1);
        end
        if (v.n_tx == 0) chk({nm, "_no_memreq"}, req_hi, 0);
        tests++;
        if (cyc < v.lat_lo || cyc > v.lat_hi) begin
            fails++;
            $display("FAIL %s_latency: got %0d cycles expected %0d..%0d", nm, cyc, v.lat_lo, v.lat_hi);
        end
        @(negedge CLK);
        chk({nm, "_single_pulse"}, {29'h0, load_completed, store_completed, flush_completed}, 32'h0);
    endtask

    vec_t vecs [9];

    initial begin
        int cyc;
        int req_hi;
        int pulses;
        bit ok;

        vecs[0] = mk(K_LOAD,  32'h19, 32'h0,        1, 32'hA5A50019, 1, 0, 32'h18, 0, 32'h0,  32'h0,        1, 100);
        vecs[1] = mk(K_LOAD,  32'h19, 32'h0,        1, 32'hA5A50019, 0, 0, 32'h0,  0, 32'h0,  32'h0,        3, 3);
        vecs[2] = mk(K_STORE, 32'h19, 32'h19,       0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  32'h0,        3, 3);
        vecs[3] = mk(K_LOAD,  32'h19, 32'h0,        1, 32'h00000019, 0, 0, 32'h0,  0, 32'h0,  32'h0,        3, 3);
        vecs[4] = mk(K_LOAD,  32'h59, 32'h0,        1, 32'hA5A50059, 1, 0, 32'h58, 0, 32'h0,  32'h0,        1, 100);
        vecs[5] = mk(K_LOAD,  32'h99, 32'h0,        1, 32'hA5A50099, 2, 1, 32'h18, 0, 32'h98, 32'h19,       1, 100);
        vecs[6] = mk(K_STORE, 32'h59, 32'hDEADBEEF, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  32'h0,        3, 3);
        vecs[7] = mk(K_FLUSH, 32'h0,  32'h0,        0, 32'h0,        1, 1, 32'h58, 0, 32'h0,  32'hDEADBEEF, 1, 100);
        vecs[8] = mk(K_FLUSH, 32'h0,  32'h0,        0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  32'h0,        1, 10);

        // Reset state
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_data", data, 32'h0);
        chk("rst_flags", {26'h0, load_completed, store_completed, flush_completed, busy, mem_req, mem_we},
            32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata[31:0] | mem_wdata[63:32] | mem_wdata[95:64] | mem_wdata[127:96],
            32'h0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // LOAD and STORE together: LOAD served first, STORE taken afterwards.
        input_address = 32'h19;
        input_data    = 32'h77;
        LOAD  = 1'b1;
        STORE = 1'b1;
        wait_pulse(K_LOAD, cyc, ok, req_hi);
        LOAD = 1'b0;
        chk("both_load_pulse", {31'h0, ok}, 32'h1);
        chk("both_load_data", data, 32'h00000019);
        chk("both_no_early_store", {31'h0, store_completed}, 32'h0);
        wait_pulse(K_STORE, cyc, ok, req_hi);
        STORE = 1'b0;
        chk("both_store_pulse", {31'h0, ok}, 32'h1);
        @(negedge CLK);
        run_vec(mk(K_LOAD, 32'h19, 32'h0, 1, 32'h77, 0, 0, 32'h0, 0, 32'h0, 32'h0, 3, 3), "both_reload");

        // Reset while a refill is outstanding.
        input_address = 32'h101;
        LOAD = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (mem_req) begin
                ok = 1'b1;
                break;
            end
        end
        chk("abort_req_seen", {31'h0, ok}, 32'h1);
        chk("abort_refill_addr", mem_addr, 32'h100);
        RST  = 1'b1;
        LOAD = 1'b0;
        @(negedge CLK);
        chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            pulses += int'(load_completed) + int'(store_completed) + int'(flush_completed);
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_data_cleared", data, 32'h0);
        run_vec(mk(K_LOAD, 32'h19, 32'h0, 1, 32'h00000019, 1, 0, 32'h18, 0, 32'h0, 32'h0, 1, 100),
                "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
